// File: rtl/syscall_sequencer_pkg.sv
// Shared definitions for the SYSCALL sequencer: service codes, bus widths,
// and the 3-bit state encoding.
package syscall_sequencer_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned LANE_W = 2;

    // Service codes carried in $v0
    localparam logic [WORD_W-1:0] SYS_PUTS = 32'd4;
    localparam logic [WORD_W-1:0] SYS_EXIT = 32'd10;

    typedef enum logic [2:0] {
        SQ_IDLE     = 3'd0,
        SQ_SETTLE   = 3'd1,
        SQ_DISPATCH = 3'd2,
        SQ_FETCH    = 3'd3,
        SQ_EMIT     = 3'd4,
        SQ_DONE     = 3'd5,
        SQ_HALT     = 3'd6
    } sq_state_e;

endpackage

// File: rtl/syscall_sequencer_byte_lane_sel.sv
// Little-endian byte lane selector: lane 0 is word[7:0], lane 3 is word[31:24].
// Ports:
//   i_word  in  32  memory word
//   i_lane  in  2   byte offset within the word
//   o_byte  out 8   selected byte (combinational)
module syscall_sequencer_byte_lane_sel
    import syscall_sequencer_pkg::*;
(
    input  logic [WORD_W-1:0] i_word,
    input  logic [LANE_W-1:0] i_lane,
    output logic [BYTE_W-1:0] o_byte
);

    always_comb begin
        o_byte = i_word[7:0];
        case (i_lane)
            2'd0: o_byte = i_word[7:0];
            2'd1: o_byte = i_word[15:8];
            2'd2: o_byte = i_word[23:16];
            2'd3: o_byte = i_word[31:24];
            default: o_byte = i_word[7:0];
        endcase
    end

endmodule

// File: rtl/syscall_sequencer.sv
// SYSCALL sequencer: stalls the pipeline on a decoded SYSCALL, waits for the
// register file to settle, dispatches on $v0, streams a NUL-terminated string
// from data memory to the console for puts, and halts on exit.
// Ports:
//   clk, rst_n            clock / async active-low reset
//   syscall_req           decoder flags current instruction as SYSCALL
//   vreg, areg            $v0 (service code) and $a0 (string address)
//   stall, busy           pipeline freeze / sequencer active
//   mem_req, mem_addr     word read request and word-aligned address
//   mem_rdata, mem_ack    read data and 1-cycle completion pulse
//   con_valid, con_data   console byte stream, con_ready handshake
//   halt                  sticky exit indication
//   bad_syscall           1-cycle pulse on unsupported service code
module syscall_sequencer
    import syscall_sequencer_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned MAX_STR_LEN   = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              syscall_req,
    input  logic [WORD_W-1:0] vreg,
    input  logic [WORD_W-1:0] areg,
    output logic              stall,
    output logic              busy,
    output logic              mem_req,
    output logic [WORD_W-1:0] mem_addr,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              con_valid,
    output logic [BYTE_W-1:0] con_data,
    input  logic              con_ready,
    output logic              halt,
    output logic              bad_syscall
);

    localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int unsigned LEN_W = $clog2(MAX_STR_LEN + 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [LEN_W-1:0] LEN_MAX     = LEN_W'(MAX_STR_LEN);

    sq_state_e         r_state;
    sq_state_e         w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [WORD_W-1:0] r_ptr;
    logic [WORD_W-1:0] w_ptr_nxt;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  w_len_nxt;
    logic [WORD_W-1:0] r_word;
    logic [WORD_W-1:0] w_word_nxt;

    logic [BYTE_W-1:0] w_byte;
    logic [WORD_W-1:0] w_ptr_inc;
    logic [LEN_W-1:0]  w_len_inc;

    assign w_ptr_inc = r_ptr + 32'd1;
    assign w_len_inc = r_len + LEN_W'(1);

    // Current string byte out of the latched memory word
    syscall_sequencer_byte_lane_sel u_lane_sel (
        .i_word (r_word),
        .i_lane (r_ptr[1:0]),
        .o_byte (w_byte)
    );

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SQ_IDLE;
            r_cnt   <= '0;
            r_ptr   <= '0;
            r_len   <= '0;
            r_word  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ptr   <= w_ptr_nxt;
            r_len   <= w_len_nxt;
            r_word  <= w_word_nxt;
        end
    end

    // Next-state and output decode
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ptr_nxt   = r_ptr;
        w_len_nxt   = r_len;
        w_word_nxt  = r_word;
        stall       = 1'b0;
        busy        = 1'b0;
        mem_req     = 1'b0;
        mem_addr    = '0;
        con_valid   = 1'b0;
        con_data    = '0;
        halt        = 1'b0;
        bad_syscall = 1'b0;

        case (r_state)
            SQ_IDLE: begin
                // Stall in the same cycle the request appears
                if (syscall_req) begin
                    stall       = 1'b1;
                    w_cnt_nxt   = SETTLE_LOAD;
                    w_state_nxt = SQ_SETTLE;
                end
            end
            SQ_SETTLE: begin
                stall = 1'b1;
                busy  = 1'b1;
                if (r_cnt == '0) begin
                    w_state_nxt = SQ_DISPATCH;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            SQ_DISPATCH: begin
                stall = 1'b1;
                busy  = 1'b1;
                if (vreg == SYS_PUTS) begin
                    w_ptr_nxt   = areg;
                    w_len_nxt   = '0;
                    w_state_nxt = SQ_FETCH;
                end else if (vreg == SYS_EXIT) begin
                    w_state_nxt = SQ_HALT;
                end else begin
                    bad_syscall = 1'b1;
                    w_state_nxt = SQ_DONE;
                end
            end
            SQ_FETCH: begin
                stall    = 1'b1;
                busy     = 1'b1;
                mem_req  = 1'b1;
                mem_addr = {r_ptr[WORD_W-1:2], 2'b00};
                if (mem_ack) begin
                    w_word_nxt  = mem_rdata;
                    w_state_nxt = SQ_EMIT;
                end
            end
            SQ_EMIT: begin
                stall = 1'b1;
                busy  = 1'b1;
                // NUL terminates the string and is never sent
                if (w_byte == 8'h00) begin
                    w_state_nxt = SQ_DONE;
                end else begin
                    con_valid = 1'b1;
                    con_data  = w_byte;
                    if (con_ready) begin
                        w_ptr_nxt = w_ptr_inc;
                        w_len_nxt = w_len_inc;
                        // Length cap wins over crossing into the next word
                        if (w_len_inc == LEN_MAX) begin
                            w_state_nxt = SQ_DONE;
                        end else if (w_ptr_inc[1:0] == 2'b00) begin
                            w_state_nxt = SQ_FETCH;
                        end
                    end
                end
            end
            SQ_DONE: begin
                // One unstalled cycle lets the pipeline retire the SYSCALL
                busy        = 1'b1;
                w_state_nxt = SQ_IDLE;
            end
            SQ_HALT: begin
                stall = 1'b1;
                busy  = 1'b1;
                halt  = 1'b1;
            end
            default: begin
                w_state_nxt = SQ_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_syscall_sequencer.sv
// Self-checking bench for syscall_sequencer: table of puts/bad vectors plus
// directed halt and mid-stream reset sequences. Memory and console are modelled
// on the falling edge; the main thread samples 1 time unit after the rising edge.
module tb_syscall_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        syscall_req;
    logic [31:0] vreg;
    logic [31:0] areg;
    logic        stall;
    logic        busy;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_ack   = 1'b0;
    logic        con_valid;
    logic [7:0]  con_data;
    logic        con_ready = 1'b0;
    logic        halt;
    logic        bad_syscall;

    syscall_sequencer #(
        .SETTLE_CYCLES (4),
        .MAX_STR_LEN   (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .syscall_req (syscall_req),
        .vreg        (vreg),
        .areg        (areg),
        .stall       (stall),
        .busy        (busy),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .con_valid   (con_valid),
        .con_data    (con_data),
        .con_ready   (con_ready),
        .halt        (halt),
        .bad_syscall (bad_syscall)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Environment models, written only by the falling-edge process
    logic [31:0] mem [0:1023];
    int          ack_dly  = 0;
    int          rdy_mode = 0;   // 0: always ready, 1: toggling, 2: never ready
    int          wait_cnt = 0;
    logic [7:0]  got_q[$];
    logic [31:0] fetch_q[$];
    int          stab_err = 0;
    int          bad_cnt  = 0;
    int          done_cnt = 0;
    logic        hold     = 1'b0;
    logic [7:0]  hold_data = 8'd0;

    always @(negedge clk) begin
        if (!rst_n) begin
            mem_ack  = 1'b0;
            wait_cnt = 0;
            hold     = 1'b0;
        end else begin
            if (mem_ack) begin
                mem_ack = 1'b0;
            end else if (mem_req) begin
                if (wait_cnt >= ack_dly) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem[mem_addr[11:2]];
                    fetch_q.push_back(mem_addr);
                    wait_cnt  = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
            if (hold && (!con_valid || con_data != hold_data)) stab_err++;
            case (rdy_mode)
                0:       con_ready = 1'b1;
                1:       con_ready = ~con_ready;
                default: con_ready = 1'b0;
            endcase
            if (con_valid && con_ready) got_q.push_back(con_data);
            hold      = con_valid && !con_ready;
            hold_data = con_data;
            if (bad_syscall) bad_cnt++;
            if (busy && !stall) done_cnt++;
        end
    end

    typedef struct {
        logic [31:0] vreg;
        logic [31:0] areg;
        logic [31:0] w0;
        logic [31:0] w1;
        int          ack_dly;
        int          rdy_mode;
        int          exp_n;
        logic [63:0] exp_bytes;
        int          exp_fetch;
        int          exp_bad;
        int          exp_lat;     // -1: not checked
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise syscall_req from IDLE and wait (bounded) for the DONE cycle
    task automatic issue(input logic [31:0] v, input logic [31:0] a, input string tag,
                         output int lat, output bit ok);
        bit started;
        vreg        = v;
        areg        = a;
        syscall_req = 1'b1;
        #1;
        chk({tag, "_stall_comb"}, 64'({stall, busy}), 64'(2'b10));
        started = 1'b0;
        lat     = 0;
        ok      = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (started) lat++;
            if (busy && !started) started = 1'b1;
            if (busy && !stall) begin
                ok = 1'b1;
                break;
            end
        end
        syscall_req = 1'b0;
    endtask

    task automatic run_vec(input int idx);
        logic [31:0] b;
        logic [63:0] pk;
        int          gb, fb, sb, bb, db, lat;
        bit          ok, addr_ok;
        string       t;
        t = $sformatf("v%0d", idx);
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        b = vecs[idx].areg & 32'hFFFF_FFFC;
        mem[b[11:2]]              = vecs[idx].w0;
        mem[10'(b[11:2] + 10'd1)] = vecs[idx].w1;
        ack_dly  = vecs[idx].ack_dly;
        rdy_mode = vecs[idx].rdy_mode;
        gb = got_q.size();
        fb = fetch_q.size();
        sb = stab_err;
        bb = bad_cnt;
        db = done_cnt;
        issue(vecs[idx].vreg, vecs[idx].areg, t, lat, ok);
        chk({t, "_timeout"}, 64'(ok), 64'(1));
        tick();
        tick();
        pk = 64'd0;
        for (int k = gb; k < got_q.size(); k++)
            if (k - gb < 8) pk[8*(k-gb) +: 8] = got_q[k];
        addr_ok = 1'b1;
        for (int k = fb; k < fetch_q.size(); k++)
            if (fetch_q[k] !== b + 32'(4 * (k - fb))) addr_ok = 1'b0;
        chk({t, "_nbytes"},     64'(got_q.size() - gb),   64'(vecs[idx].exp_n));
        chk({t, "_bytes"},      pk,                       vecs[idx].exp_bytes);
        chk({t, "_fetches"},    64'(fetch_q.size() - fb), 64'(vecs[idx].exp_fetch));
        chk({t, "_fetch_addr"}, 64'(addr_ok),             64'(1));
        chk({t, "_bad_pulse"},  64'(bad_cnt - bb),        64'(vecs[idx].exp_bad));
        chk({t, "_done_cyc"},   64'(done_cnt - db),       64'(1));
        chk({t, "_con_stable"}, 64'(stab_err - sb),       64'(0));
        chk({t, "_idle"},       64'({stall, busy, halt}), 64'(0));
        if (vecs[idx].exp_lat >= 0)
            chk({t, "_latency"}, 64'(lat), 64'(vecs[idx].exp_lat));
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({stall, busy, mem_req, mem_addr, con_valid, con_data, halt, bad_syscall});
    endfunction

    initial begin
        int  lat, fb, db, stall_lo;
        bit  ok, started;

        vecs[0] = '{32'd4, 32'h100, 32'h006C6C65, 32'h0,        0, 0, 3, 64'h6C6C65,   1, 0, -1};
        vecs[1] = '{32'd4, 32'h102, 32'h49481111, 32'h00000021, 1, 1, 3, 64'h214948,   2, 0, -1};
        vecs[2] = '{32'd7, 32'h0,   32'h0,        32'h0,        0, 0, 0, 64'h0,        0, 1, 5};
        vecs[3] = '{32'd4, 32'h200, 32'h44434241, 32'h00004645, 0, 0, 4, 64'h44434241, 1, 0, -1};
        vecs[4] = '{32'd4, 32'h300, 32'h0,        32'h0,        2, 0, 0, 64'h0,        1, 0, 9};
        vecs[5] = '{32'd4, 32'h307, 32'h5A000000, 32'h0,        0, 1, 1, 64'h5A,       2, 0, -1};

        rst_n       = 1'b0;
        syscall_req = 1'b0;
        vreg        = 32'd0;
        areg        = 32'd0;
        tick();
        chk("reset_outs", all_outs(), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("idle_outs", all_outs(), 64'd0);

        for (int v = 0; v < 6; v++) run_vec(v);

        // Exit: halt one cycle after DISPATCH, stall held against further requests
        rdy_mode = 0;
        ack_dly  = 0;
        fb = fetch_q.size();
        db = done_cnt;
        vreg = 32'd10;
        areg = 32'd0;
        syscall_req = 1'b1;
        started = 1'b0;
        ok = 1'b0;
        lat = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (started) lat++;
            if (busy && !started) started = 1'b1;
            if (halt) begin
                ok = 1'b1;
                break;
            end
        end
        chk("halt_timeout", 64'(ok), 64'(1));
        chk("halt_latency", 64'(lat), 64'(5));
        chk("halt_outs", 64'({halt, stall, busy, bad_syscall}), 64'(4'b1110));
        vreg = 32'd4;
        stall_lo = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!stall || !halt) stall_lo++;
        end
        chk("halt_sticky", 64'(stall_lo), 64'(0));
        chk("halt_no_fetch", 64'(fetch_q.size() - fb), 64'(0));
        chk("halt_no_done", 64'(done_cnt - db), 64'(0));
        syscall_req = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("halt_reset", all_outs(), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Asynchronous reset while a byte is waiting on the console
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        mem[10'h040] = 32'h006C6C65;
        ack_dly  = 3;
        rdy_mode = 2;
        fb = fetch_q.size();
        vreg = 32'd4;
        areg = 32'h100;
        syscall_req = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (con_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk("emit_timeout", 64'(ok), 64'(1));
        chk("emit_first", 64'(con_data), 64'(8'h65));
        tick();
        tick();
        chk("emit_held", 64'({con_valid, con_data}), 64'({1'b1, 8'h65}));
        chk("emit_fetches", 64'(fetch_q.size() - fb), 64'(1));
        rst_n = 1'b0;
        syscall_req = 1'b0;
        #1;
        chk("emit_reset", all_outs(), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_reset", all_outs(), 64'd0);
        run_vec(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
